dvb_s2_ts_qpsk_front: RTL and testbench

- Transport-stream front end and symbol mapper at the entry of the DVB-S2 transmit chain.
- Accepts 188-byte MPEG-TS packets one byte per strobe, aligns them to packet boundaries and buffers them in a FIFO.
- Re-emits buffered bytes with packet markers and maps them MSB-first onto QPSK symbols.
- Produces a 1x symbol-rate stream and a 2x zero-stuffed stream for the downstream shaping filter.

---
 rtl/dvb_s2_ts_qpsk_front.sv | 211 +++++++++++++++++++++
 tb/tb_dvb_s2_ts_qpsk_front.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvb_s2_ts_qpsk_front.sv
// DVB-S2 transport-stream front end: packet alignment, byte FIFO, QPSK mapper
// with a 1x symbol stream and a 2x zero-stuffed stream for the shaping filter.
// Input bytes arrive on a strobe (ts_valid_h264out) with no backpressure; a byte
// offered while the FIFO is full is dropped and flagged on fifo_ovf.
`timescale 1ns/1ps
module dvb_s2_ts_qpsk_front #(
    parameter int PACK_BYTE_SIZE = 188,
    parameter int FIFO_DEPTH     = 16,
    parameter int SYM_DIV        = 4,
    parameter int AMP            = 23170
) (
    input  logic               sys_clk,
    input  logic               hard_rst_n,
    input  logic               ts_valid_h264out,
    input  logic               ts_syn_h264out,
    input  logic [7:0]         ts_din_h264out,
    input  logic               fs_en_outer,
    input  logic               fs_en2_outer,
    output logic               ts_clk,
    output logic [7:0]         ts_din,
    output logic               ts_syn,
    output logic               ts_head,
    output logic               symbol_1x_oe,
    output logic signed [15:0] symbol_1x_re_out,
    output logic signed [15:0] symbol_1x_im_out,
    output logic               symbol_2x_oe,
    output logic signed [15:0] symbol_2x_re_out,
    output logic signed [15:0] symbol_2x_im_out,
    output logic               fifo_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(PACK_BYTE_SIZE);
    localparam int DW = $clog2(SYM_DIV);
    localparam logic signed [15:0] AMP_P = 16'(AMP);
    localparam logic signed [15:0] AMP_N = -AMP_P;

    // Alignment state
    logic          lock_q, lock_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    // FIFO state: pointers carry one extra wrap bit to tell full from empty
    logic [8:0]    fifo_mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    // Symbol timing and mapper state
    logic [DW-1:0] div_q, div_d;
    logic [7:0]    sh_q, sh_d;
    logic [1:0]    scnt_q, scnt_d;
    logic          stuff_q, stuff_d;
    // Registered outputs
    logic          ts_clk_q, ts_clk_d;
    logic [7:0]    ts_din_q, ts_din_d;
    logic          ts_syn_q, ts_syn_d;
    logic          ts_head_q, ts_head_d;
    logic          oe1_q, oe1_d;
    logic signed [15:0] re1_q, re1_d, im1_q, im1_d;
    logic          oe2_q, oe2_d;
    logic signed [15:0] re2_q, re2_d, im2_q, im2_d;

    // Combinational helpers
    logic          fifo_empty, fifo_full;
    logic          stb_int, stb2_int, stb, stb2;
    logic          in_take, push, pop, produce;
    logic          head_in;
    logic [8:0]    rd_word;
    logic [1:0]    pair;
    logic signed [15:0] map_re, map_im;

    // Symbol strobes: internal divider, 2x pulses phase-aligned to 1x pulses
    always_comb begin
        stb_int  = (div_q == DW'(SYM_DIV - 1));
        stb2_int = stb_int || (div_q == DW'(SYM_DIV / 2 - 1));
        stb      = fs_en_outer  | stb_int;
        stb2     = fs_en2_outer | stb2_int;
        div_d    = stb_int ? '0 : div_q + 1'b1;
    end

    // Packet alignment and FIFO write/overflow control
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_word    = fifo_mem_q[rd_ptr_q[AW-1:0]];
        pop        = stb && (scnt_q == 2'd0) && !fifo_empty;
        lock_d     = lock_q;
        pcnt_d     = pcnt_q;
        in_take    = ts_valid_h264out && (ts_syn_h264out || lock_q);
        if (ts_valid_h264out && ts_syn_h264out) begin
            lock_d = 1'b1;
            pcnt_d = '0;
        end else if (ts_valid_h264out && lock_q) begin
            pcnt_d = (pcnt_q == CW'(PACK_BYTE_SIZE - 1)) ? '0 : pcnt_q + 1'b1;
        end
        head_in  = (pcnt_d == '0);
        // A full FIFO still accepts a byte when a pop frees a slot this cycle
        push     = in_take && (!fifo_full || pop);
        ovf_d    = ovf_q | (in_take && fifo_full && !pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    // QPSK mapper, byte re-emission and 2x zero-stuffing
    always_comb begin
        produce   = stb && ((scnt_q != 2'd0) || !fifo_empty);
        pair      = pop ? rd_word[7:6] : sh_q[7:6];
        map_re    = pair[1] ? AMP_N : AMP_P;
        map_im    = pair[0] ? AMP_N : AMP_P;
        sh_d      = sh_q;
        scnt_d    = scnt_q;
        ts_clk_d  = ts_clk_q;
        ts_din_d  = ts_din_q;
        ts_head_d = ts_head_q;
        ts_syn_d  = pop;
        oe1_d     = produce;
        re1_d     = re1_q;
        im1_d     = im1_q;
        oe2_d     = 1'b0;
        re2_d     = re2_q;
        im2_d     = im2_q;
        stuff_d   = stuff_q;
        if (pop) begin
            sh_d      = {rd_word[5:0], 2'b00};
            scnt_d    = 2'd3;
            ts_clk_d  = ~ts_clk_q;
            ts_din_d  = rd_word[7:0];
            ts_head_d = rd_word[8];
        end else if (produce) begin
            sh_d   = {sh_q[5:0], 2'b00};
            scnt_d = scnt_q - 2'd1;
        end
        if (produce) begin
            re1_d = map_re;
            im1_d = map_im;
        end
        if (stb2 && produce) begin
            oe2_d   = 1'b1;
            re2_d   = map_re;
            im2_d   = map_im;
            stuff_d = 1'b1;
        end else if (stb2 && stuff_q) begin
            oe2_d   = 1'b1;
            re2_d   = '0;
            im2_d   = '0;
            stuff_d = 1'b0;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate every read
    always_ff @(posedge sys_clk) begin
        if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {head_in, ts_din_h264out};
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge hard_rst_n) begin
        if (!hard_rst_n) begin
            lock_q    <= 1'b0;
            pcnt_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            div_q     <= '0;
            sh_q      <= '0;
            scnt_q    <= '0;
            stuff_q   <= 1'b0;
            ts_clk_q  <= 1'b0;
            ts_din_q  <= '0;
            ts_syn_q  <= 1'b0;
            ts_head_q <= 1'b0;
            oe1_q     <= 1'b0;
            re1_q     <= '0;
            im1_q     <= '0;
            oe2_q     <= 1'b0;
            re2_q     <= '0;
            im2_q     <= '0;
        end else begin
            lock_q    <= lock_d;
            pcnt_q    <= pcnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            div_q     <= div_d;
            sh_q      <= sh_d;
            scnt_q    <= scnt_d;
            stuff_q   <= stuff_d;
            ts_clk_q  <= ts_clk_d;
            ts_din_q  <= ts_din_d;
            ts_syn_q  <= ts_syn_d;
            ts_head_q <= ts_head_d;
            oe1_q     <= oe1_d;
            re1_q     <= re1_d;
            im1_q     <= im1_d;
            oe2_q     <= oe2_d;
            re2_q     <= re2_d;
            im2_q     <= im2_d;
        end
    end

    assign ts_clk           = ts_clk_q;
    assign ts_din           = ts_din_q;
    assign ts_syn           = ts_syn_q;
    assign ts_head          = ts_head_q;
    assign symbol_1x_oe     = oe1_q;
    assign symbol_1x_re_out = re1_q;
    assign symbol_1x_im_out = im1_q;
    assign symbol_2x_oe     = oe2_q;
    assign symbol_2x_re_out = re2_q;
    assign symbol_2x_im_out = im2_q;
    assign fifo_ovf         = ovf_q;

endmodule

// File: tb/tb_dvb_s2_ts_qpsk_front.sv
// Bench for dvb_s2_ts_qpsk_front: directed steps feeding a scoreboard of
// expected popped bytes and expected QPSK symbols.
`timescale 1ns/1ps
module tb_dvb_s2_ts_qpsk_front;
    localparam int PACK = 188;

    // Clock and DUT signals
    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic               hard_rst_n;
    logic               ts_valid_h264out, ts_syn_h264out;
    logic [7:0]         ts_din_h264out;
    logic               fs_en_outer, fs_en2_outer;
    logic               ts_clk, ts_syn, ts_head;
    logic [7:0]         ts_din;
    logic               symbol_1x_oe, symbol_2x_oe, fifo_ovf;
    logic signed [15:0] symbol_1x_re_out, symbol_1x_im_out;
    logic signed [15:0] symbol_2x_re_out, symbol_2x_im_out;

    dvb_s2_ts_qpsk_front dut (
        .sys_clk(sys_clk), .hard_rst_n(hard_rst_n),
        .ts_valid_h264out(ts_valid_h264out), .ts_syn_h264out(ts_syn_h264out),
        .ts_din_h264out(ts_din_h264out),
        .fs_en_outer(fs_en_outer), .fs_en2_outer(fs_en2_outer),
        .ts_clk(ts_clk), .ts_din(ts_din), .ts_syn(ts_syn), .ts_head(ts_head),
        .symbol_1x_oe(symbol_1x_oe), .symbol_1x_re_out(symbol_1x_re_out),
        .symbol_1x_im_out(symbol_1x_im_out),
        .symbol_2x_oe(symbol_2x_oe), .symbol_2x_re_out(symbol_2x_re_out),
        .symbol_2x_im_out(symbol_2x_im_out),
        .fifo_ovf(fifo_ovf)
    );

    // Scoreboard state
    int          checks = 0;
    int          errors = 0;
    logic [8:0]  exp_byte_q[$];
    logic [31:0] exp_sym_q[$];
    int          n_1x = 0, n_2x = 0, n_tsyn = 0, n_head = 0;
    bit          stuff_due = 1'b0;
    bit          tclk_exp = 1'b0;
    bit          m_lock = 1'b0;
    int          m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sym_of(input logic [1:0] p);
        logic signed [15:0] re, im;
        re = p[1] ? -16'sd23170 : 16'sd23170;
        im = p[0] ? -16'sd23170 : 16'sd23170;
        return {re, im};
    endfunction

    // Output monitor: compares every popped byte and produced symbol
    task automatic monitor();
        logic [8:0]  eb;
        logic [31:0] es;
        forever begin
            @(negedge sys_clk);
            if (!hard_rst_n) begin
                exp_byte_q.delete();
                exp_sym_q.delete();
                stuff_due = 1'b0;
                tclk_exp  = 1'b0;
            end else begin
                if (ts_syn) begin
                    chk("byte_expected", 32'(exp_byte_q.size() != 0), 1);
                    if (exp_byte_q.size() != 0) begin
                        eb = exp_byte_q.pop_front();
                        chk("ts_head_din", {23'd0, ts_head, ts_din}, {23'd0, eb});
                    end
                    tclk_exp = ~tclk_exp;
                    chk("ts_clk", 32'(ts_clk), 32'(tclk_exp));
                    n_tsyn++;
                    if (ts_head) n_head++;
                end
                if (symbol_1x_oe) begin
                    chk("sym_expected", 32'(exp_sym_q.size() != 0), 1);
                    if (exp_sym_q.size() != 0) begin
                        es = exp_sym_q.pop_front();
                        chk("sym1x", {symbol_1x_re_out, symbol_1x_im_out}, es);
                        chk("sym2x", {symbol_2x_re_out, symbol_2x_im_out}, es);
                    end
                    chk("oe2_with_1x", 32'(symbol_2x_oe), 1);
                    stuff_due = 1'b1;
                    n_1x++;
                    if (symbol_2x_oe) n_2x++;
                end else if (symbol_2x_oe) begin
                    chk("stuff_due", 32'(stuff_due), 1);
                    chk("stuff_zero", {symbol_2x_re_out, symbol_2x_im_out}, 0);
                    stuff_due = 1'b0;
                    n_2x++;
                end
            end
        end
    endtask

    // Driver: one byte strobe, with the bench's own alignment model
    task automatic send_byte(input logic [7:0] b, input bit syn, input bit keep);
        bit take;
        @(posedge sys_clk); #1;
        ts_valid_h264out = 1'b1;
        ts_syn_h264out   = syn;
        ts_din_h264out   = b;
        take = syn || m_lock;
        if (syn) begin
            m_lock = 1'b1;
            m_cnt  = 0;
        end else if (m_lock) begin
            m_cnt = (m_cnt == PACK - 1) ? 0 : m_cnt + 1;
        end
        if (take && keep) begin
            exp_byte_q.push_back({(m_cnt == 0), b});
            exp_sym_q.push_back(sym_of(b[7:6]));
            exp_sym_q.push_back(sym_of(b[5:4]));
            exp_sym_q.push_back(sym_of(b[3:2]));
            exp_sym_q.push_back(sym_of(b[1:0]));
        end
    endtask

    task automatic idle(input int n);
        @(posedge sys_clk); #1;
        ts_valid_h264out = 1'b0;
        ts_syn_h264out   = 1'b0;
        repeat (n - 1) @(posedge sys_clk);
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int k;
        k = 0;
        while ((exp_sym_q.size() != 0 || exp_byte_q.size() != 0) && k < max_cycles) begin
            @(posedge sys_clk);
            k++;
        end
        chk(tag, 32'(exp_sym_q.size() + exp_byte_q.size()), 0);
        repeat (4) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, "_ts_clk"}, 32'(ts_clk), 0);
        chk({p, "_ts_din"}, 32'(ts_din), 0);
        chk({p, "_ts_syn"}, 32'(ts_syn), 0);
        chk({p, "_ts_head"}, 32'(ts_head), 0);
        chk({p, "_oe1"}, 32'(symbol_1x_oe), 0);
        chk({p, "_sym1x"}, {symbol_1x_re_out, symbol_1x_im_out}, 0);
        chk({p, "_oe2"}, 32'(symbol_2x_oe), 0);
        chk({p, "_sym2x"}, {symbol_2x_re_out, symbol_2x_im_out}, 0);
        chk({p, "_ovf"}, 32'(fifo_ovf), 0);
    endtask

    task automatic apply_reset();
        @(posedge sys_clk); #1;
        hard_rst_n = 1'b0;
        ts_valid_h264out = 1'b0;
        ts_syn_h264out = 1'b0;
        m_lock = 1'b0;
        m_cnt = 0;
        repeat (2) @(posedge sys_clk);
        #1;
        hard_rst_n = 1'b1;
    endtask

    // Directed sequence
    initial begin
        int b1x, b2x, bsyn, bhead;
        hard_rst_n       = 1'b0;
        ts_valid_h264out = 1'b0;
        ts_syn_h264out   = 1'b0;
        ts_din_h264out   = 8'h00;
        fs_en_outer      = 1'b0;
        fs_en2_outer     = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        chk_all_zero("reset");
        @(posedge sys_clk); #1;
        hard_rst_n = 1'b1;

        // Bytes before any syn are dropped
        b1x = n_1x; bsyn = n_tsyn;
        send_byte(8'hAA, 1'b0, 1'b1);
        send_byte(8'h55, 1'b0, 1'b1);
        idle(64);
        chk("unlocked_tsyn", 32'(n_tsyn - bsyn), 0);
        chk("unlocked_sym", 32'(n_1x - b1x), 0);

        // One packet starting 0x47: symbols (+,-),(+,+),(+,-),(-,-) lead off
        b1x = n_1x; bhead = n_head;
        for (int i = 0; i < PACK; i++) begin
            send_byte((i == 0) ? 8'h47 : 8'($urandom_range(0, 255)), i == 0, 1'b1);
            idle(15);
        end
        drain("pkt1_drain", 2000);
        chk("pkt1_heads", 32'(n_head - bhead), 1);
        chk("pkt1_syms", 32'(n_1x - b1x), 4 * PACK);

        // Seven contiguous packets, one byte per four symbol periods
        b1x = n_1x; b2x = n_2x; bhead = n_head;
        for (int p = 0; p < 7; p++) begin
            for (int i = 0; i < PACK; i++) begin
                send_byte((i == 0) ? 8'h47 : 8'($urandom_range(0, 255)), i == 0, 1'b1);
                idle(15);
            end
        end
        drain("pkt7_drain", 2000);
        chk("pkt7_syms", 32'(n_1x - b1x), 4 * 1316);
        chk("pkt7_2x", 32'(n_2x - b2x), 8 * 1316);
        chk("pkt7_heads", 32'(n_head - bhead), 7);
        chk("pkt7_ovf", 32'(fifo_ovf), 0);

        // Syn at byte 100 restarts the count; next head 188 bytes later
        bhead = n_head;
        for (int i = 0; i <= 100 + PACK; i++) begin
            send_byte(8'($urandom_range(0, 255)), (i == 0) || (i == 100), 1'b1);
            idle(15);
        end
        drain("midsyn_drain", 2000);
        chk("midsyn_heads", 32'(n_head - bhead), 3);

        // Reset mid-symbol: outputs clear at once, nothing until a new syn
        send_byte(8'h47, 1'b1, 1'b1);
        idle(15);
        send_byte(8'hC3, 1'b0, 1'b1);
        idle(6);
        @(posedge sys_clk); #3;
        hard_rst_n = 1'b0;
        m_lock = 1'b0;
        m_cnt = 0;
        #1;
        chk_all_zero("midrst");
        repeat (2) @(posedge sys_clk);
        #1;
        hard_rst_n = 1'b1;
        b1x = n_1x; bsyn = n_tsyn;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h5A, 1'b0, 1'b1);
            idle(3);
        end
        idle(80);
        chk("postrst_tsyn", 32'(n_tsyn - bsyn), 0);
        chk("postrst_sym", 32'(n_1x - b1x), 0);

        // Back-to-back burst of FIFO_DEPTH+3 bytes straight after reset.
        // Byte 0 lands two edges after release and is popped on the first
        // strobe (4 cycles after release); the next pop comes 16 cycles later.
        // The FIFO fills with byte 16, byte 17 meets a full FIFO with no pop
        // and is lost, byte 18 coincides with that next pop and is kept.
        apply_reset();
        bsyn = n_tsyn;
        for (int i = 0; i < 19; i++) begin
            send_byte(8'($urandom_range(0, 255)), i == 0, i != 17);
        end
        idle(2);
        chk("burst_ovf", 32'(fifo_ovf), 1);
        drain("burst_drain", 4000);
        chk("burst_bytes", 32'(n_tsyn - bsyn), 18);
        chk("burst_ovf_sticky", 32'(fifo_ovf), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
